gtxe2_chnl_rate_ctrl: RTL and testbench

//  Sequences run-time line-rate changes (TXRATE/RXRATE) for one direction of the GTXE2 channel clocking model.

---
 rtl/gtxe2_chnl_rate_ctrl.sv | 141 ++++++++++++++
 tb/tb_gtxe2_chnl_rate_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gtxe2_chnl_rate_ctrl.sv
// Run-time line-rate change sequencer for one direction of the GTXE2 channel clocking model.
// Debounces the requested rate, gates the dividers while switching, then waits for PLL lock.
module gtxe2_chnl_rate_ctrl #(
    parameter int unsigned SETTLE_CYC   = 4,
    parameter int unsigned GATE_CYC     = 8,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rate_in,
    input  logic       pll_locked,
    output logic [2:0] rate_out,
    output logic       div_reset,
    output logic       busy,
    output logic       rate_done,
    output logic       rate_err
);

    localparam int unsigned RATE_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_WAIT_LOCK,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [RATE_W-1:0]  target_q, target_d;
    logic [RATE_W-1:0]  rate_out_q, rate_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lock_seen_q, lock_seen_d;
    logic               div_reset_q, div_reset_d;
    logic               busy_q, busy_d;
    logic               rate_done_q, rate_done_d;
    logic               rate_err_q, rate_err_d;
    logic [RATE_W-1:0]  rate_norm;

    // Reserved codes 110/111 behave exactly like 000.
    assign rate_norm = (rate_in >= RATE_W'(6)) ? '0 : rate_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            rate_out_q  <= '0;
            cnt_q       <= '0;
            lock_seen_q <= 1'b0;
            div_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            rate_done_q <= 1'b0;
            rate_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            rate_out_q  <= rate_out_d;
            cnt_q       <= cnt_d;
            lock_seen_q <= lock_seen_d;
            div_reset_q <= div_reset_d;
            busy_q      <= busy_d;
            rate_done_q <= rate_done_d;
            rate_err_q  <= rate_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        rate_out_d  = rate_out_q;
        cnt_d       = cnt_q;
        lock_seen_d = 1'b0;
        rate_err_d  = rate_err_q;

        case (state_q)
            S_IDLE: begin
                if (rate_norm != rate_out_q) begin
                    target_d = rate_norm;
                    cnt_d    = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (rate_norm != target_q) begin
                    target_d = rate_norm;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d = '0;
                    // A request that settles back onto the applied code is dropped silently.
                    if (target_q == rate_out_q) begin
                        state_d = S_IDLE;
                    end else begin
                        rate_out_d = target_q;
                        state_d    = S_GATE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GATE: begin
                if (cnt_q == CNT_W'(GATE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (pll_locked && lock_seen_q) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_d      = '0;
                    rate_err_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    lock_seen_d = pll_locked;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        div_reset_d = (state_d == S_GATE);
        busy_d      = (state_d != S_IDLE);
        rate_done_d = (state_d == S_DONE);
    end

    assign rate_out  = rate_out_q;
    assign div_reset = div_reset_q;
    assign busy      = busy_q;
    assign rate_done = rate_done_q;
    assign rate_err  = rate_err_q;

endmodule

// File: tb/tb_gtxe2_chnl_rate_ctrl.sv
// Scoreboard bench for gtxe2_chnl_rate_ctrl: directed rate changes, expected completions queued
// by the stimulus and matched by an independent monitor on every rate_done pulse.
module tb_gtxe2_chnl_rate_ctrl;

    localparam int unsigned GATE_CYC = 8;
    // rate_done rises on the 15th edge counting the detecting IDLE edge as the first.
    localparam int LAT_OK      = 15;
    localparam int LAT_TIMEOUT = 1037;

    logic       clk;
    logic       rst_n;
    logic [2:0] rate_in;
    logic       pll_locked;
    logic [2:0] rate_out;
    logic       div_reset;
    logic       busy;
    logic       rate_done;
    logic       rate_err;

    typedef struct {
        logic [2:0] rate;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   cyc;
    int   checks;
    int   errors;
    bit   prev_done;
    int   div_run;

    gtxe2_chnl_rate_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rate_in    (rate_in),
        .pll_locked (pll_locked),
        .rate_out   (rate_out),
        .div_reset  (div_reset),
        .busy       (busy),
        .rate_done  (rate_done),
        .rate_err   (rate_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: pops one expectation per rate_done pulse and checks pulse width and div_reset length.
    always @(negedge clk) begin
        if (rst_n && rate_done) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width: rate_done high on consecutive cycles at cyc %0d", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: rate_done at cyc %0d with nothing expected", cyc);
            end else begin
                got = sb.pop_front();
                if (rate_out !== got.rate || rate_err !== got.err || cyc != got.cyc) begin
                    errors++;
                    $display("FAIL done_match: got rate=%0h err=%0b cyc=%0d, expected rate=%0h err=%0b cyc=%0d",
                             rate_out, rate_err, cyc, got.rate, got.err, got.cyc);
                end
            end
        end
        prev_done = rst_n && rate_done;

        if (!rst_n) begin
            div_run = 0;
        end else if (div_reset) begin
            div_run++;
        end else if (div_run != 0) begin
            checks++;
            if (div_run != int'(GATE_CYC)) begin
                errors++;
                $display("FAIL div_len: div_reset high %0d cycles, expected %0d", div_run, GATE_CYC);
            end
            div_run = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [2:0] rate, input logic err, input int lat);
        exp_t e;
        e.rate = rate;
        e.err  = err;
        e.cyc  = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(sb.size()), 32'd0);
        tick(3);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_div_rise(input string name, input logic [2:0] rate, input int exp_cyc);
        int k;
        k = 0;
        while (!div_reset && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_seen"}, 32'(div_reset), 32'd1);
        chk({name, "_cyc"}, 32'(cyc), 32'(exp_cyc));
        chk({name, "_rate"}, 32'(rate_out), 32'(rate));
    endtask

    initial begin
        int  t0;
        bit  any;
        checks     = 0;
        errors     = 0;
        prev_done  = 1'b0;
        div_run    = 0;
        rst_n      = 1'b1;
        rate_in    = 3'b111;
        pll_locked = 1'b1;
        #2 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        chk("rst_rate_out", 32'(rate_out), 32'd0);
        chk("rst_div_reset", 32'(div_reset), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rate_done", 32'(rate_done), 32'd0);
        chk("rst_rate_err", 32'(rate_err), 32'd0);

        // Reserved code 111 must look like 000: nothing starts.
        any = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any = any | busy | div_reset;
        end
        chk("t5_no_seq", 32'(any), 32'd0);

        // Short glitch to 010 is withdrawn during SETTLE.
        rate_in = 3'b010;
        tick(2);
        rate_in = 3'b000;
        any = 1'b0;
        repeat (14) begin
            @(negedge clk);
            any = any | div_reset | rate_done;
        end
        chk("t2_no_gate", 32'(any), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_rate_out", 32'(rate_out), 32'd0);

        // Plain change 000 -> 011 with lock present.
        rate_in = 3'b011;
        t0 = cyc;
        push(3'b011, 1'b0, LAT_OK);
        wait_div_rise("t1_div", 3'b011, t0 + 5);
        wait_drain("t1_drain");
        chk("t1_rate_out", 32'(rate_out), 32'd3);

        // Change to 001, then 101 arrives during GATE and runs afterwards.
        rate_in = 3'b001;
        t0 = cyc;
        push(3'b001, 1'b0, LAT_OK);
        wait_div_rise("t4_div", 3'b001, t0 + 5);
        rate_in = 3'b101;
        sb.push_back('{rate: 3'b101, err: 1'b0, cyc: t0 + 16 + LAT_OK});
        wait_drain("t4_drain");
        chk("t4_rate_out", 32'(rate_out), 32'd5);

        // Asynchronous reset in the middle of GATE, then a full restart to 011.
        rate_in = 3'b000;
        t0 = cyc;
        wait_div_rise("t6_div", 3'b000, t0 + 5);
        tick(2);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_div", 32'(div_reset), 32'd0);
        chk("t6_async_rate", 32'(rate_out), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        rate_in = 3'b011;
        tick(2);
        rst_n = 1'b1;
        push(3'b011, 1'b0, LAT_OK);
        wait_drain("t6_drain");

        // Lock never arrives: timeout sets the sticky error.
        rst_n = 1'b0;
        rate_in = 3'b000;
        pll_locked = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("t3_err_cleared", 32'(rate_err), 32'd0);
        rate_in = 3'b100;
        push(3'b100, 1'b1, LAT_TIMEOUT);
        wait_drain("t3_drain");
        chk("t3_rate_out", 32'(rate_out), 32'd4);
        tick(5);
        chk("t3_err_sticky", 32'(rate_err), 32'd1);

        // A later successful change leaves the error set.
        pll_locked = 1'b1;
        rate_in = 3'b010;
        push(3'b010, 1'b1, LAT_OK);
        wait_drain("t3b_drain");

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
